// File: rtl/line_endpoint_regs.sv
// Double-buffered line endpoint bank feeding the Bresenham drawer.
// Shadow set is written over Avalon-MM and swapped in at the blanking row.
module line_endpoint_regs #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic [10:0] x_cnt,
  input  logic [9:0]  y_cnt,
  output logic [10:0] x0,
  output logic [9:0]  y0,
  output logic [10:0] x1,
  output logic [9:0]  y1,
  output logic        line_en,
  output logic        frame_tick
);

  localparam logic [10:0] XMAX  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  YMAX  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  YSWAP = 10'(V_ACTIVE);

  logic [10:0] r_sx0, r_sx1;
  logic [9:0]  r_sy0, r_sy1;
  logic        r_sen;
  logic        r_pending;
  logic [15:0] r_frame_cnt;
  logic        r_at_swap;
  logic        r_at_swap_d;
  logic [10:0] r_x0, r_x1;
  logic [9:0]  r_y0, r_y1;
  logic        r_en;
  logic [31:0] r_rdata;

  logic        w_wr_p0;
  logic        w_wr_p1;
  logic        w_wr_ctrl;
  logic        w_commit;
  logic        w_at_swap;
  logic        w_tick;
  logic        w_swap;
  logic [10:0] w_cx0, w_cx1;
  logic [9:0]  w_cy0, w_cy1;
  logic        w_order;
  logic [10:0] w_nx0, w_nx1;
  logic [9:0]  w_ny0, w_ny1;
  logic [31:0] w_rmux;
  logic        w_unused;

  assign w_wr_p0   = avs_write && (avs_address == 3'd0);
  assign w_wr_p1   = avs_write && (avs_address == 3'd1);
  assign w_wr_ctrl = avs_write && (avs_address == 3'd2);
  assign w_commit  = w_wr_ctrl && avs_writedata[0];
  assign w_unused  = ^{avs_writedata[31:26], avs_writedata[15:11]};

  assign w_at_swap = (x_cnt == 11'd0) && (y_cnt == YSWAP);
  assign w_tick    = r_at_swap && !r_at_swap_d;
  assign w_swap    = w_tick && r_pending;

  assign w_cx0 = (r_sx0 > XMAX) ? XMAX : r_sx0;
  assign w_cx1 = (r_sx1 > XMAX) ? XMAX : r_sx1;
  assign w_cy0 = (r_sy0 > YMAX) ? YMAX : r_sy0;
  assign w_cy1 = (r_sy1 > YMAX) ? YMAX : r_sy1;

  // Strictly greater only, so equal rows keep the written order.
  assign w_order = w_cy0 > w_cy1;
  assign w_nx0   = w_order ? w_cx1 : w_cx0;
  assign w_ny0   = w_order ? w_cy1 : w_cy0;
  assign w_nx1   = w_order ? w_cx0 : w_cx1;
  assign w_ny1   = w_order ? w_cy0 : w_cy1;

  always_comb begin
    w_rmux = 32'd0;
    unique case (avs_address)
      3'd0:    w_rmux = {6'd0, r_sy0, 5'd0, r_sx0};
      3'd1:    w_rmux = {6'd0, r_sy1, 5'd0, r_sx1};
      3'd2:    w_rmux = {30'd0, r_sen, 1'b0};
      3'd3:    w_rmux = {r_frame_cnt, 15'd0, r_pending};
      default: w_rmux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_at_swap   <= 1'b0;
      r_at_swap_d <= 1'b0;
    end else begin
      r_at_swap   <= w_at_swap;
      r_at_swap_d <= r_at_swap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sx0 <= '0;
      r_sy0 <= '0;
      r_sx1 <= '0;
      r_sy1 <= '0;
      r_sen <= 1'b0;
    end else begin
      if (w_wr_p0) begin
        r_sx0 <= avs_writedata[10:0];
        r_sy0 <= avs_writedata[25:16];
      end
      if (w_wr_p1) begin
        r_sx1 <= avs_writedata[10:0];
        r_sy1 <= avs_writedata[25:16];
      end
      if (w_wr_ctrl) begin
        r_sen <= avs_writedata[1];
      end
    end
  end

  // A swap consumes the pending commit; a commit landing on that edge is absorbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_swap) begin
        r_pending <= 1'b0;
      end else if (w_commit) begin
        r_pending <= 1'b1;
      end
      if (w_tick) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_en <= 1'b0;
    end else if (w_swap) begin
      r_x0 <= w_nx0;
      r_y0 <= w_ny0;
      r_x1 <= w_nx1;
      r_y1 <= w_ny1;
      r_en <= r_sen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (avs_read) begin
      r_rdata <= w_rmux;
    end
  end

  assign x0           = r_x0;
  assign y0           = r_y0;
  assign x1           = r_x1;
  assign y1           = r_y1;
  assign line_en      = r_en;
  assign frame_tick   = w_tick;
  assign avs_readdata = r_rdata;

endmodule

// File: tb/tb_line_endpoint_regs.sv
// Bench for line_endpoint_regs: directed scenarios plus a random run
// against a frame-level reference model of the register bank.
module tb_line_endpoint_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [10:0] x_cnt = 11'd5;
  logic [9:0]  y_cnt = 10'd10;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic        line_en;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_endpoint_regs #(.H_ACTIVE(800), .V_ACTIVE(480)) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_read(avs_read),
    .avs_readdata(avs_readdata),
    .x_cnt(x_cnt), .y_cnt(y_cnt),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .line_en(line_en), .frame_tick(frame_tick)
  );

  int m_sx[2], m_sy[2];
  int m_ax[2], m_ay[2];
  bit m_sen, m_en, m_pend;
  int m_cnt;
  bit m_h1, m_h2;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
    end
    m_sen = 0; m_en = 0; m_pend = 0; m_cnt = 0; m_h1 = 0; m_h2 = 0;
  endtask

  function automatic logic [31:0] pt(input int x, input int y);
    return (32'(y) << 16) | 32'(x);
  endfunction

  function automatic logic [31:0] rdval(input int a);
    case (a)
      0: return pt(m_sx[0], m_sy[0]);
      1: return pt(m_sx[1], m_sy[1]);
      2: return 32'(m_sen) << 1;
      3: return (32'(m_cnt) << 16) | 32'(m_pend);
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_swap();
    int cx[2], cy[2];
    for (int i = 0; i < 2; i++) begin
      cx[i] = (m_sx[i] > 799) ? 799 : m_sx[i];
      cy[i] = (m_sy[i] > 479) ? 479 : m_sy[i];
    end
    if (cy[0] > cy[1]) begin
      m_ax[0] = cx[1]; m_ay[0] = cy[1]; m_ax[1] = cx[0]; m_ay[1] = cy[0];
    end else begin
      m_ax[0] = cx[0]; m_ay[0] = cy[0]; m_ax[1] = cx[1]; m_ay[1] = cy[1];
    end
    m_en = m_sen;
  endtask

  // One clock: entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit wr, input int a, input logic [31:0] d,
                     input bit rd, input int xc, input int yc);
    bit tick;
    logic [31:0] exp_rd;
    avs_write = wr; avs_address = 3'(a); avs_writedata = d;
    avs_read = rd; x_cnt = 11'(xc); y_cnt = 10'(yc);
    tick = m_h1 && !m_h2;
    checks++;
    if (frame_tick !== tick) begin
      errors++;
      $display("FAIL frame_tick got %b want %b t=%0t", frame_tick, tick, $time);
    end
    checks++;
    if ({x0, y0, x1, y1, line_en} !==
        {11'(m_ax[0]), 10'(m_ay[0]), 11'(m_ax[1]), 10'(m_ay[1]), m_en}) begin
      errors++;
      $display("FAIL outputs got %0d,%0d,%0d,%0d,%b want %0d,%0d,%0d,%0d,%b t=%0t",
               x0, y0, x1, y1, line_en, m_ax[0], m_ay[0], m_ax[1], m_ay[1], m_en, $time);
    end
    exp_rd = rdval(a);
    @(posedge clk);
    if (tick) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (m_pend) begin
        do_swap();
        m_pend = 0;
      end else if (wr && a == 2 && d[0]) m_pend = 1;
    end else if (wr && a == 2 && d[0]) m_pend = 1;
    if (wr) begin
      if (a == 0) begin m_sx[0] = int'(d[10:0]); m_sy[0] = int'(d[25:16]); end
      if (a == 1) begin m_sx[1] = int'(d[10:0]); m_sy[1] = int'(d[25:16]); end
      if (a == 2) m_sen = d[1];
    end
    m_h2 = m_h1;
    m_h1 = (xc == 0 && yc == 480);
    #1;
    avs_write = 1'b0; avs_read = 1'b0;
    if (rd) begin
      checks++;
      if (avs_readdata !== exp_rd) begin
        errors++;
        $display("FAIL readdata a=%0d got %h want %h t=%0t", a, avs_readdata, exp_rd, $time);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 5, 10);
  endtask
  task automatic wr(input int a, input logic [31:0] d);
    cyc(1, a, d, 0, 5, 10);
  endtask
  task automatic rd(input int a);
    cyc(0, a, 0, 1, 5, 10);
  endtask
  task automatic frame();
    cyc(0, 0, 0, 0, 0, 480);
    idle(2);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({x0, y0, x1, y1, line_en, frame_tick, avs_readdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %0d,%0d,%0d,%0d,%b,%b,%h want zeros",
               x0, y0, x1, y1, line_en, frame_tick, avs_readdata);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    rd(3);
    checks++;
    if (avs_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_status got %h want 0", avs_readdata);
    end
  endtask

  task automatic test_basic();
    wr(0, pt(100, 50));
    wr(1, pt(300, 200));
    wr(2, 32'h3);
    rd(3);
    checks++;
    if (avs_readdata !== 32'h1) begin
      errors++;
      $display("FAIL basic_pending got %h want 00000001", avs_readdata);
    end
    frame();
    checks++;
    if ({x0, y0, x1, y1, line_en} !== {11'd100, 10'd50, 11'd300, 10'd200, 1'b1}) begin
      errors++;
      $display("FAIL basic_swap got %0d,%0d,%0d,%0d,%b want 100,50,300,200,1",
               x0, y0, x1, y1, line_en);
    end
    rd(3);
    checks++;
    if (avs_readdata !== 32'h0001_0000) begin
      errors++;
      $display("FAIL basic_status got %h want 00010000", avs_readdata);
    end
  endtask

  task automatic test_clamp_order();
    wr(0, pt(10, 400));
    wr(1, pt(900, 20));
    wr(2, 32'h3);
    frame();
    checks++;
    if ({x0, y0, x1, y1} !== {11'd799, 10'd20, 11'd10, 10'd400}) begin
      errors++;
      $display("FAIL clamp_order got %0d,%0d,%0d,%0d want 799,20,10,400", x0, y0, x1, y1);
    end
    wr(0, pt(2047, 1023));
    wr(1, pt(3, 1000));
    wr(2, 32'h1);
    frame();
    checks++;
    if ({x0, y0, x1, y1, line_en} !== {11'd799, 10'd479, 11'd3, 10'd479, 1'b0}) begin
      errors++;
      $display("FAIL clamp_equal got %0d,%0d,%0d,%0d,%b want 799,479,3,479,0",
               x0, y0, x1, y1, line_en);
    end
  endtask

  task automatic test_commit_on_tick();
    wr(0, pt(1, 1));
    wr(1, pt(2, 2));
    cyc(0, 0, 0, 0, 0, 480);
    cyc(1, 2, 32'h3, 0, 5, 10);
    idle(2);
    checks++;
    if ({x0, y0, x1, y1} !== {11'd799, 10'd479, 11'd3, 10'd479}) begin
      errors++;
      $display("FAIL commit_tick_hold got %0d,%0d,%0d,%0d want 799,479,3,479",
               x0, y0, x1, y1);
    end
    rd(3);
    checks++;
    if (avs_readdata[0] !== 1'b1) begin
      errors++;
      $display("FAIL commit_tick_pend got %b want 1", avs_readdata[0]);
    end
    frame();
    checks++;
    if ({x0, y0, x1, y1, line_en} !== {11'd1, 10'd1, 11'd2, 10'd2, 1'b1}) begin
      errors++;
      $display("FAIL commit_tick_swap got %0d,%0d,%0d,%0d,%b want 1,1,2,2,1",
               x0, y0, x1, y1, line_en);
    end
  endtask

  task automatic test_write_in_swap();
    wr(0, pt(50, 60));
    wr(1, pt(70, 80));
    wr(2, 32'h3);
    cyc(0, 0, 0, 0, 0, 480);
    cyc(1, 1, pt(400, 300), 0, 5, 10);
    idle(1);
    checks++;
    if ({x1, y1} !== {11'd70, 10'd80}) begin
      errors++;
      $display("FAIL swap_write_old got %0d,%0d want 70,80", x1, y1);
    end
    rd(1);
    checks++;
    if (avs_readdata !== pt(400, 300)) begin
      errors++;
      $display("FAIL swap_write_rb got %h want %h", avs_readdata, pt(400, 300));
    end
    wr(2, 32'h3);
    frame();
    checks++;
    if ({x0, y0, x1, y1} !== {11'd50, 10'd60, 11'd400, 10'd300}) begin
      errors++;
      $display("FAIL swap_write_new got %0d,%0d,%0d,%0d want 50,60,400,300",
               x0, y0, x1, y1);
    end
  endtask

  task automatic test_hold();
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 480);
      n += int'(frame_tick);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n += int'(frame_tick);
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL hold_single_tick got %0d ticks want 1", n);
    end
  endtask

  task automatic test_wrap();
    force dut.r_frame_cnt = 16'hFFFF;
    idle(1);
    release dut.r_frame_cnt;
    m_cnt = 65535;
    rd(3);
    checks++;
    if (avs_readdata[31:16] !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload got %h want ffff", avs_readdata[31:16]);
    end
    frame();
    rd(3);
    checks++;
    if (avs_readdata[31:16] !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_zero got %h want 0000", avs_readdata[31:16]);
    end
  endtask

  task automatic test_reset_pending();
    wr(0, pt(5, 6));
    wr(2, 32'h3);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({x0, y0, x1, y1, line_en} !== '0) begin
      errors++;
      $display("FAIL async_reset got %0d,%0d,%0d,%0d,%b want zeros",
               x0, y0, x1, y1, line_en);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    rd(3);
    checks++;
    if (avs_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_pend got %h want 0", avs_readdata);
    end
    frame();
    checks++;
    if ({x0, y0, x1, y1, line_en} !== '0) begin
      errors++;
      $display("FAIL reset_lost got %0d,%0d,%0d,%0d,%b want zeros",
               x0, y0, x1, y1, line_en);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      int r, xc, yc, a;
      bit w, rr;
      logic [31:0] d;
      r = int'($urandom_range(0, 7));
      if (r < 2) begin xc = 0; yc = 480; end
      else if (r == 2) begin xc = 1; yc = 480; end
      else if (r == 3) begin xc = 0; yc = 479; end
      else begin xc = int'($urandom_range(0, 1055)); yc = int'($urandom_range(0, 524)); end
      w = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 1) == 0);
      a = int'($urandom_range(0, 7));
      d = $urandom;
      if (a < 2 && d[0]) d = pt(int'($urandom_range(0, 850)), int'($urandom_range(0, 520)));
      cyc(w, a, d, rr, xc, yc);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_clamp_order();
    test_commit_on_tick();
    test_write_in_swap();
    test_hold();
    test_wrap();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
